// File: rtl/cnn_pkg.sv
// ============================================================================
// Module   : cnn_pkg
// Brief    : Shared data type and window-sequencer state encoding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cnn_pkg;

  localparam int DATA_W = 32;

  typedef logic signed [DATA_W-1:0] data_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    DRAIN = 3'd2,
    EMIT  = 3'd3,
    DONE  = 3'd4
  } conv_state_e;

endpackage

`default_nettype wire

// File: rtl/conv_acc.sv
// ============================================================================
// Module   : conv_acc
// Brief    : Clearable multiply-accumulate; product and sum wrap at DATA_W.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_acc
  import cnn_pkg::*;
(
  input  logic  clk,
  input  logic  rstn,
  input  logic  en,
  input  logic  clr,
  input  data_t a,
  input  data_t b,
  output data_t acc
);

  data_t r_acc;
  data_t w_prod;

  assign w_prod = a * b;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_acc <= '0;
    end else if (en) begin
      r_acc <= (clr ? data_t'('0) : r_acc) + w_prod;
    end
  end

  assign acc = r_acc;

endmodule

`default_nettype wire

// File: rtl/conv_window_ctrl.sv
// ============================================================================
// Module   : conv_window_ctrl
// Brief    : Sweeps KxK windows over a feature map, drives buffer reads and a
//            MAC, and emits one (optionally ReLU'd) pixel per window.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_window_ctrl
  import cnn_pkg::*;
#(
  parameter  int DATA_W = cnn_pkg::DATA_W,
  parameter  int IMG_H  = 4,
  parameter  int IMG_W  = 4,
  parameter  int K      = 3,
  localparam int c_oh   = IMG_H - K + 1,
  localparam int c_ow   = IMG_W - K + 1,
  localparam int c_aw   = (IMG_H * IMG_W > 1) ? $clog2(IMG_H * IMG_W) : 1,
  localparam int c_waw  = (K > 1) ? $clog2(K * K) : 1,
  localparam int c_rw   = (c_oh > 1) ? $clog2(c_oh) : 1,
  localparam int c_cw   = (c_ow > 1) ? $clog2(c_ow) : 1,
  localparam int c_kw   = (K > 1) ? $clog2(K) : 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             relu_en,
  output logic             busy,
  output logic             done,
  output logic             ifm_rd_en,
  output logic [c_aw-1:0]  ifm_addr,
  input  data_t            ifm_rdata,
  output logic             wgt_rd_en,
  output logic [c_waw-1:0] wgt_addr,
  input  data_t            wgt_rdata,
  output logic             out_valid,
  input  logic             out_ready,
  output data_t            out_data,
  output logic [c_rw-1:0]  out_row,
  output logic [c_cw-1:0]  out_col
);

  if (K > IMG_H || K > IMG_W) begin : g_bad_geometry
    $error("conv_window_ctrl: kernel K larger than feature map");
  end
  if (DATA_W != $bits(data_t)) begin : g_bad_width
    $error("conv_window_ctrl: DATA_W must match cnn_pkg::data_t");
  end

  conv_state_e     r_state, w_next;
  logic [c_rw-1:0] r_row;
  logic [c_cw-1:0] r_col;
  logic [c_kw-1:0] r_kr, r_kc;
  logic            r_relu;
  logic            r_rd_vld;
  logic            r_first_vld;
  data_t           w_acc;
  logic            w_last_tap, w_last_pos, w_first_tap;

  assign w_first_tap = (r_kr == '0) && (r_kc == '0);
  assign w_last_tap  = (r_kr == c_kw'(K - 1)) && (r_kc == c_kw'(K - 1));
  assign w_last_pos  = (r_row == c_rw'(c_oh - 1)) && (r_col == c_cw'(c_ow - 1));

  // Read data returns one cycle after the strobe, so the MAC runs one cycle behind.
  conv_acc u_acc (
    .clk  (clk),
    .rstn (rstn),
    .en   (r_rd_vld),
    .clr  (r_first_vld),
    .a    (ifm_rdata),
    .b    (wgt_rdata),
    .acc  (w_acc)
  );

  always_comb begin
    w_next    = r_state;
    busy      = 1'b0;
    done      = 1'b0;
    ifm_rd_en = 1'b0;
    wgt_rd_en = 1'b0;
    ifm_addr  = '0;
    wgt_addr  = '0;
    out_valid = 1'b0;
    out_data  = '0;
    out_row   = '0;
    out_col   = '0;
    case (r_state)
      IDLE: begin
        if (start) w_next = ISSUE;
      end
      ISSUE: begin
        busy      = 1'b1;
        ifm_rd_en = 1'b1;
        wgt_rd_en = 1'b1;
        ifm_addr  = c_aw'((int'(r_row) + int'(r_kr)) * IMG_W + int'(r_col) + int'(r_kc));
        wgt_addr  = c_waw'(int'(r_kr) * K + int'(r_kc));
        if (w_last_tap) w_next = DRAIN;
      end
      DRAIN: begin
        busy   = 1'b1;
        w_next = EMIT;
      end
      EMIT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = (r_relu && w_acc[DATA_W-1]) ? data_t'('0) : w_acc;
        out_row   = r_row;
        out_col   = r_col;
        if (out_ready) w_next = w_last_pos ? DONE : ISSUE;
      end
      DONE: begin
        busy   = 1'b1;
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= IDLE;
      r_row       <= '0;
      r_col       <= '0;
      r_kr        <= '0;
      r_kc        <= '0;
      r_relu      <= 1'b0;
      r_rd_vld    <= 1'b0;
      r_first_vld <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_rd_vld    <= (r_state == ISSUE);
      r_first_vld <= (r_state == ISSUE) && w_first_tap;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_relu <= relu_en;
            r_row  <= '0;
            r_col  <= '0;
            r_kr   <= '0;
            r_kc   <= '0;
          end
        end
        ISSUE: begin
          if (r_kc == c_kw'(K - 1)) begin
            r_kc <= '0;
            r_kr <= (r_kr == c_kw'(K - 1)) ? '0 : r_kr + 1'b1;
          end else begin
            r_kc <= r_kc + 1'b1;
          end
        end
        EMIT: begin
          // Raster advance on handshake; the final position leaves r/c untouched.
          if (out_ready && !w_last_pos) begin
            if (r_col == c_cw'(c_ow - 1)) begin
              r_col <= '0;
              r_row <= r_row + 1'b1;
            end else begin
              r_col <= r_col + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
